// File: rtl/temp_sensor_pkg.sv
// Shared constants and state encoding for the I2C temperature-sensor target.
package temp_sensor_pkg;

  localparam logic [6:0] DEFAULT_BUS_ADDR = 7'h48;
  localparam logic [7:0] DEFAULT_DEV_ID   = 8'hCB;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_STATUS   = 8'h02;
  localparam logic [7:0] REG_CONFIG   = 8'h03;
  localparam logic [7:0] REG_DEV_ID   = 8'h0B;

  localparam logic [7:0] STATUS_VALUE = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_MACK
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the raw SCL/SDA pads into the clk domain and flags SCL edges plus
// START/STOP conditions, all derived from the synchronized copies.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // Bits [1:0] are the synchronizer, bit [2] is the previous synchronized value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target exposing a coherent temperature sample, a config register and a
// device ID through an auto-incrementing register pointer.
module i2c_temp_responder
  import temp_sensor_pkg::*;
#(
  parameter logic [6:0] BUS_ADDR = DEFAULT_BUS_ADDR,
  parameter logic [7:0] DEV_ID   = DEFAULT_DEV_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_value,
  input  logic        temp_load,
  output logic [7:0]  config_q,
  output logic        reg_wr,
  output logic [7:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_in),
    .sda_i     (sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (bus_start),
    .stop_o    (bus_stop)
  );

  state_e      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        reg_wr_q, reg_wr_d;
  logic [15:0] staging_q, staging_d;
  logic [15:0] shadow_q, shadow_d;
  logic [7:0]  rd_byte;

  always_comb begin
    case (ptr_q)
      REG_TEMP_MSB: rd_byte = shadow_q[15:8];
      REG_TEMP_LSB: rd_byte = shadow_q[7:0];
      REG_STATUS:   rd_byte = STATUS_VALUE;
      REG_CONFIG:   rd_byte = cfg_q;
      REG_DEV_ID:   rd_byte = DEV_ID;
      default:      rd_byte = 8'h00;
    endcase
  end

  // In the ACK states bitcnt acts as a flag: 0 = ACK not yet driven, 1 = ACK clock seen.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    tx_d      = tx_q;
    cfg_d     = cfg_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    reg_wr_d  = 1'b0;
    staging_d = temp_load ? temp_value : staging_q;
    shadow_d  = shadow_q;

    if (bus_stop) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (bus_start) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      if (!busy_q) begin
        shadow_d = staging_d;
      end
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d[3'd7 - bitcnt_q[2:0]] = sda_s;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                if (shift_d[7:1] == BUS_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = sda_s;
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = shift_d;
                state_d = ST_PTR_ACK;
              end else begin
                reg_wr_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_d;
                if (ptr_q == REG_CONFIG) begin
                  cfg_d = shift_d;
                end
                ptr_d   = ptr_q + 8'd1;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            bitcnt_d = 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd0) begin
            sda_oe_d = 1'b1;
          end else if (scl_fall) begin
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d  = ST_RDATA;
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 8'd1;
            state_d  = ST_RD_MACK;
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[3'd7 - bitcnt_q[2:0]];
          end
        end
        ST_RD_MACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_IDLE;
            end else begin
              bitcnt_d = 4'd1;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            bitcnt_d = 4'd0;
            state_d  = ST_RDATA;
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      tx_q      <= 8'h00;
      cfg_q     <= 8'h00;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      reg_wr_q  <= 1'b0;
      staging_q <= 16'h0000;
      shadow_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      tx_q      <= tx_d;
      cfg_q     <= cfg_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      reg_wr_q  <= reg_wr_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign config_q    = cfg_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;

endmodule

// File: doc/i2c_temp_responder.md
I2C_TEMP_RESPONDER -- requirements
Module: i2c_temp_responder

Interface
REQ-001 Parameter BUS_ADDR, 7'h48: the 7-bit I2C target address that this block answers to.
REQ-002 Parameter DEV_ID, 8'hCB: the value returned from the ID register 0x0B.
REQ-003 clk  in  1  system clock (100 MHz); reset  in  1  reset, asynchronous, active-high.
REQ-004 scl_in  in  1  raw SCL from the pad, asynchronous to clk.
REQ-005 sda_in  in  1  raw SDA from the pad, asynchronous to clk.
REQ-006 sda_oe  out  1  1 = pull SDA low; 0 = release SDA (open-drain, so the pad logic drives 0 or Z).
REQ-007 temp_value  in  16  new temperature sample, {MSB,LSB}; temp_load  in  1  one-cycle strobe that captures temp_value.
REQ-008 config_q  out  8  current contents of the configuration register (0x03).
REQ-009 reg_wr  out  1  one-cycle pulse per accepted write byte; reg_wr_addr  out  8  pointer of that write; reg_wr_data  out  8  the byte written.
REQ-010 busy  out  1  high from an address match until the next STOP or START.

Function
REQ-011 scl_in and sda_in SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized signals.
REQ-012 START = SDA falls while SCL is high; STOP = SDA rises while SCL is high. START and STOP SHALL be recognised in every state.
REQ-013 A START in any state (including a repeated START) SHALL move to ADDR with the bit counter cleared; a STOP SHALL move to IDLE with sda_oe=0.
REQ-014 Bits SHALL be sampled on the synchronized SCL rising edge, MSB first; the first 8 bits after START form the address byte.
REQ-015 sda_oe SHALL change only within 2 clk after a synchronized SCL falling edge, never while SCL is high.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK.
REQ-017 ADDR: on the 8th bit, if addr[7:1]==BUS_ADDR, go to ADDR_ACK and drive ACK for one SCL low period. On mismatch, keep sda_oe=0, go to IDLE, and ignore the bus until the next START.
REQ-018 After ADDR_ACK: R/W=0 goes to PTR; R/W=1 goes to RDATA. On entry to RDATA, drive the MSB of the addressed register on the same SCL falling edge that releases the ACK.
REQ-019 PTR: the 8 received bits load the pointer, which is then ACKed; after that, each further byte goes through WDATA then WDATA_ACK.
REQ-020 WDATA: the byte SHALL always be ACKed, reg_wr SHALL pulse once on the 8th rising edge, and the pointer SHALL then increment modulo 256.
REQ-021 Write map: 0x03 updates config_q. Writes to any other address SHALL still pulse reg_wr but change no internal state.
REQ-022 Read map: 0x00 returns temp MSB, 0x01 temp LSB, 0x02 status 8'h00, 0x03 config_q, 0x0B DEV_ID; every other address returns 8'h00.
REQ-023 After each read byte the pointer SHALL increment modulo 256 (0xFF wraps to 0x00).
REQ-024 RD_MACK: on the 9th rising edge, controller ACK (SDA=0) continues to the next byte; NACK goes to IDLE with SDA released.
REQ-025 temp_load SHALL write a staging register. The staging register SHALL be copied into the readable temperature shadow only on START while not busy, so MSB/LSB read within one transaction are always coherent.
REQ-026 If temp_load and the shadow copy occur in the same cycle, the shadow SHALL take the new temp_value.

Reset
REQ-027 Reset values: sda_oe=0, state=IDLE, pointer=0x00, config_q=8'h00, staging and shadow=16'h0000, reg_wr=0, reg_wr_addr=0, reg_wr_data=0, busy=0; synchronizers preset to 1 (idle bus).
REQ-028 Reset asserted mid-transfer SHALL release SDA within the same cycle (asynchronous) and the block SHALL ignore the bus until the next START.

Structure
REQ-029 temp_sensor_pkg SHALL hold the register-address constants (0x00, 0x01, 0x02, 0x03, 0x0B), the state enum, and the default BUS_ADDR/DEV_ID.
REQ-030 One sub-module, i2c_line_sync, SHALL provide the synchronizer and SCL rise/fall and START/STOP detection; everything else SHALL live in i2c_temp_responder.

Verification
REQ-031 temp_load 16'h0C80; write {0x90, ptr 0x00}; repeated START; read {0x91} 2 bytes, ACK then NACK -> returns 0x0C, 0x80; every ACK slot has SDA=0.
REQ-032 Write {0x90, 0x03, 0xA0} -> reg_wr pulses once with addr 0x03/data 0xA0; config_q=0xA0; a following read of 0x03 returns 0xA0.
REQ-033 Address 0x92 -> sda_oe stays 0 throughout, busy=0, and no reg_wr pulse.
REQ-034 Pointer 0xFF, read 2 bytes -> 0x00 then 0x0C; the pointer has wrapped.
REQ-035 temp_load 16'h1234 between the MSB and LSB of a read of 0x00 -> the old value is read coherently; the next transaction reads 0x12, 0x34.
REQ-036 Assert reset while driving a 0 bit -> sda_oe=0 immediately; config_q=0x00; the next full transaction succeeds.
